// File: rtl/spk_memory_controller.sv
// Spike memory controller: two ping-pong spike banks, a host-loaded input-spike
// buffer and per-neuron saturating spike counters. Serves the control unit's
// per-cycle read/write commands and runs word-at-a-time clear sequences.
module spk_memory_controller #(
  parameter int unsigned N_NEURONS = 512,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned SB_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  // spike write into the current write bank
  input  logic [ADDR_W-1:0] cntrl_spk_write_addr,
  input  logic              cntrl_spk_write_we,
  input  logic              spk_in,
  // accumulator spike read
  input  logic [ADDR_W-1:0] cntrl_ac_spk_read_addr,
  input  logic [2:0]        cntrl_ac_spk_read_switch,
  output logic [7:0]        ac_spk_out,
  // input-spike buffer read
  input  logic [ADDR_W-1:0] cntrl_in_spk_read_addr,
  output logic [7:0]        in_spk_out,
  // host loader
  input  logic              host_in_spk_we,
  input  logic [ADDR_W-4:0] host_in_spk_addr,
  input  logic [7:0]        host_in_spk_data,
  // spikeability counters
  input  logic [ADDR_W-1:0] cntrl_spkblty_read_addr,
  output logic [SB_W-1:0]   spkblty_out,
  input  logic [ADDR_W-1:0] cntrl_spkblty_write_addr,
  input  logic              cntrl_spkblty_write_we,
  // sequencing
  input  logic              cntrl_step_swap,
  input  logic              cntrl_spkblty_clear,
  output logic              busy
);

  localparam int unsigned NWords = N_NEURONS / 8;
  localparam int unsigned WordW  = ADDR_W - 3;

  typedef enum logic [1:0] {
    StInitClr = 2'd0,
    StIdle    = 2'd1,
    StClrSpk  = 2'd2,
    StClrSb   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WordW-1:0] word_q, word_d;
  logic             bank_sel_q, bank_sel_d;
  logic             swap_pend_q, swap_pend_d;
  logic             clr_pend_q, clr_pend_d;

  logic             swap_req, clr_req, last_word, start_seq;

  // bank_sel_q = 0: bank0 is the write bank, bank1 the read bank
  logic [7:0]       bank0  [NWords];
  logic [7:0]       bank1  [NWords];
  logic [7:0]       in_buf [NWords];
  logic [SB_W-1:0]  sb_mem [N_NEURONS];

  logic [WordW-1:0] spk_wr_word;
  logic [2:0]       spk_wr_bit;
  logic [WordW-1:0] ac_rd_word;
  logic [WordW-1:0] in_rd_word;
  logic             spk_we_ok, sb_inc_ok, host_we_ok;
  logic             unused_low_bits;

  assign spk_wr_word = cntrl_spk_write_addr[ADDR_W-1:3];
  assign spk_wr_bit  = cntrl_spk_write_addr[2:0];
  assign ac_rd_word  = cntrl_ac_spk_read_addr[ADDR_W-1:3];
  assign in_rd_word  = cntrl_in_spk_read_addr[ADDR_W-1:3];

  // Word reads ignore the bit-select part of the address.
  assign unused_low_bits = ^{cntrl_ac_spk_read_addr[2:0], cntrl_in_spk_read_addr[2:0]};

  assign busy      = (state_q != StIdle);
  assign last_word = (word_q == WordW'(NWords - 1));

  // Writes are suppressed while reset is held and while their target is being cleared.
  assign spk_we_ok  = !reset && cntrl_spk_write_we && (state_q == StIdle || state_q == StClrSb);
  assign sb_inc_ok  = !reset && cntrl_spkblty_write_we && spk_in &&
                      (state_q == StIdle || state_q == StClrSpk);
  assign host_we_ok = !reset && host_in_spk_we && (state_q != StInitClr);

  // Next-state logic: sequence selection with one-deep pending swap/clear requests.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bank_sel_d  = bank_sel_q;
    swap_req    = swap_pend_q | cntrl_step_swap;
    clr_req     = clr_pend_q | cntrl_spkblty_clear;
    swap_pend_d = swap_req;
    clr_pend_d  = clr_req;
    start_seq   = 1'b0;

    case (state_q)
      StIdle: start_seq = 1'b1;
      StInitClr, StClrSpk, StClrSb: begin
        if (last_word) begin
          start_seq = 1'b1;
        end else begin
          word_d = word_q + WordW'(1);
        end
      end
      default: state_d = StInitClr;
    endcase

    // A swap beats a clear; the clear stays pending and runs next.
    if (start_seq) begin
      word_d = '0;
      if (swap_req) begin
        state_d     = StClrSpk;
        bank_sel_d  = ~bank_sel_q;
        swap_pend_d = 1'b0;
      end else if (clr_req) begin
        state_d    = StClrSb;
        clr_pend_d = 1'b0;
      end else begin
        state_d = StIdle;
      end
    end
  end

  // State register; reset restarts the power-on clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StInitClr;
      word_q      <= '0;
      bank_sel_q  <= 1'b0;
      swap_pend_q <= 1'b0;
      clr_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bank_sel_q  <= bank_sel_d;
      swap_pend_q <= swap_pend_d;
      clr_pend_q  <= clr_pend_d;
    end
  end

  // Spike banks: sequence clears plus single-bit spike writes into the write bank.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StInitClr) begin
        bank0[word_q] <= '0;
        bank1[word_q] <= '0;
      end else if (state_q == StClrSpk) begin
        if (bank_sel_q) begin
          bank1[word_q] <= '0;
        end else begin
          bank0[word_q] <= '0;
        end
      end
      if (spk_we_ok) begin
        if (bank_sel_q) begin
          bank1[spk_wr_word][spk_wr_bit] <= spk_in;
        end else begin
          bank0[spk_wr_word][spk_wr_bit] <= spk_in;
        end
      end
    end
  end

  // Input-spike buffer: cleared at power-on, otherwise loaded by the host.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StInitClr) begin
        in_buf[word_q] <= '0;
      end else if (host_we_ok) begin
        in_buf[host_in_spk_addr] <= host_in_spk_data;
      end
    end
  end

  // Spikeability counters: eight cleared per cycle, or one saturating increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StInitClr || state_q == StClrSb) begin
        for (int unsigned j = 0; j < 8; j++) begin
          sb_mem[{word_q, j[2:0]}] <= '0;
        end
      end else if (sb_inc_ok && (sb_mem[cntrl_spkblty_write_addr] != '1)) begin
        sb_mem[cntrl_spkblty_write_addr] <= sb_mem[cntrl_spkblty_write_addr] + SB_W'(1);
      end
    end
  end

  // Registered read ports; a same-cycle write is not visible (old data returned).
  always_ff @(posedge clk) begin
    if (reset) begin
      ac_spk_out  <= '0;
      in_spk_out  <= '0;
      spkblty_out <= '0;
    end else begin
      case (cntrl_ac_spk_read_switch)
        3'd0:    ac_spk_out <= bank_sel_q ? bank0[ac_rd_word] : bank1[ac_rd_word];
        3'd1:    ac_spk_out <= in_buf[ac_rd_word];
        default: ac_spk_out <= '0;
      endcase
      in_spk_out  <= in_buf[in_rd_word];
      spkblty_out <= sb_mem[cntrl_spkblty_read_addr];
    end
  end

endmodule

// File: doc/spk_memory_controller.md
Name: spk_memory_controller

Overview:
- Responder to the control unit's spike-memory command interface. Serves the accumulator spike reads, spike writes, input-spike reads and spikeability (spike-count) reads and writes issued every cycle by the control unit.
- Holds two ping-pong spike banks: the write bank receives the current time step, the read bank holds the previous step. It also holds an input-spike buffer loaded by the host and a per-neuron saturating spike counter.
- Sits between the control unit, the accumulators and the host loader.

Parameters:
- N_NEURONS, 512, neurons per memory; must be a multiple of 8.
- ADDR_W, 9, neuron address width, log2(N_NEURONS).
- SB_W, 8, spikeability counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cntrl_spk_write_addr  in  ADDR_W  neuron index to write in the write bank.
- cntrl_spk_write_we  in  1  spike write strobe.
- spk_in  in  1  spike value from the neuron being written.
- cntrl_ac_spk_read_addr  in  ADDR_W  read address; bits [ADDR_W-1:3] select an 8-spike word.
- cntrl_ac_spk_read_switch  in  3  read source: 0 = read bank, 1 = input buffer, others = zero.
- ac_spk_out  out  8  spike word returned to the accumulators.
- cntrl_in_spk_read_addr  in  ADDR_W  input-buffer read address (word select as above).
- in_spk_out  out  8  input-buffer word.
- host_in_spk_we  in  1  host input-buffer write strobe.
- host_in_spk_addr  in  ADDR_W-3  host word address.
- host_in_spk_data  in  8  host word data.
- cntrl_spkblty_read_addr  in  ADDR_W  spike-counter read address.
- spkblty_out  out  SB_W  spike-counter read data.
- cntrl_spkblty_write_addr  in  ADDR_W  spike-counter increment address.
- cntrl_spkblty_write_we  in  1  increment strobe; the counter increments only if spk_in=1.
- cntrl_step_swap  in  1  one-cycle pulse marking the end of a time step.
- cntrl_spkblty_clear  in  1  one-cycle pulse requesting that all counters be zeroed.
- busy  out  1  high while a clear sequence runs.

Behaviour:
- Reset:
  - Outputs go to 0. bank_sel=0 (bank0 is the write bank).
  - The FSM enters INIT_CLR with busy=1.
  - Reset asserted mid-operation aborts any sequence and restarts INIT_CLR.
- Reads:
  - All three read ports have 1-cycle latency: the address is registered and data appears on the next cycle.
  - Reads are serviced in every state, including while busy.
- Read-during-write to the same location returns the old data.
- Spike write: on cntrl_spk_write_we, bit addr[2:0] of word addr[ADDR_W-1:3] in the write bank is set to spk_in.
- Spikeability increment: on cntrl_spkblty_write_we with spk_in=1, the counter gains 1 and saturates at 2^SB_W-1.
- Back-to-back increments to the same address must both count. Example: two consecutive cycles on address 5 with the counter at 0 give 2 on the next read.
- FSM states:
  - INIT_CLR: clears word k of both spike banks, the input buffer, and counters 8k..8k+7 per cycle, for N_NEURONS/8 cycles, then goes to IDLE.
  - IDLE: busy=0.
  - CLR_SPK: clears one word per cycle of the new write bank, for N_NEURONS/8 cycles (64 at default).
  - CLR_SB: clears 8 counters per cycle, for N_NEURONS/8 cycles.
- Transitions:
  - cntrl_step_swap in IDLE: bank_sel toggles the same cycle; next state is CLR_SPK.
  - cntrl_spkblty_clear in IDLE: next state is CLR_SB.
  - Swap and clear in the same cycle: the swap wins and the clear is latched as pending. CLR_SB runs immediately after CLR_SPK.
  - A swap or clear arriving while busy is latched (one deep each) and serviced when the current sequence ends; the pending clear is serviced after a pending swap.
  - busy drops the cycle after the last word is cleared.
- While busy:
  - Spike writes into the bank being cleared are dropped.
  - Counter increments are dropped during CLR_SB and INIT_CLR.
  - Host writes are dropped during INIT_CLR only.
- Out-of-range read_switch values (2..7) return 8'h00.

Test Plan:
- Reset, then hold 64 cycles → busy=1 for exactly 64 cycles; every ac_spk_out, in_spk_out and spkblty_out read returns 0.
- Write spk_in=1 at addr 13, pulse swap, wait out busy, read addr 8 with switch=0 → ac_spk_out=8'h20.
- Host writes word 3=8'hA5; cntrl_in_spk_read_addr=24 → in_spk_out=8'hA5 one cycle later; same address with switch=1 → ac_spk_out=8'hA5.
- 300 increments with spk_in=1 at addr 7, including back-to-back cycles → spkblty_out=255; 2 more increments with spk_in=0 → still 255.
- Swap and spkblty_clear pulsed in the same cycle → busy high for 128 consecutive cycles, counters read 0 afterwards, bank_sel toggled once.
- Assert reset at cycle 30 of CLR_SPK → bank_sel=0, INIT_CLR restarts, busy high 64 more cycles, all memories read 0.
